// File: rtl/aes_key_sched.sv
// AES-128 key expansion: one schedule word per clock into a 44-word bank.
// A shared 4-lane forward S-box serves SubWord(RotWord(w[i-1])).

module sbox #(
  parameter int NUM = 4,
  parameter bit EN  = 1'b1
) (
  input  logic [8*NUM-1:0] din,
  output logic [8*NUM-1:0] dout
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // inverse as x^254; zero maps to zero
  function automatic logic [7:0] sub(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    logic [7:0] v;
    sq  = a;
    acc = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    v = acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]}
        ^ {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]};
    return v ^ 8'h63;
  endfunction

  // substitute every lane in parallel
  always_comb begin
    dout = din;
    for (int k = 0; k < NUM; k++) begin
      if (EN) dout[8*k +: 8] = sub(din[8*k +: 8]);
    end
  end

endmodule

module aes_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] w [0:43];
  logic [5:0]  i;
  logic [5:0]  wi;
  logic [7:0]  rcon;
  logic        done_q;
  logic        accept;
  logic [31:0] prev;
  logic [31:0] back4;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [31:0] nxt;
  logic [5:0]  base;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign accept    = key_valid & key_ready;
  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);
  assign rk_valid  = (state == DONE);
  assign done      = done_q;

  // i is 0 only after reset; clamp keeps bank reads in range
  assign wi    = (i < 6'd4) ? 6'd4 : i;
  assign prev  = w[wi - 6'd1];
  assign back4 = w[wi - 6'd4];
  assign rot   = {prev[23:0], prev[31:24]};

  sbox #(.NUM(4), .EN(1'b1)) u_sbox (
    .din  (rot),
    .dout (sub)
  );

  // next schedule word from w[i-1] and w[i-4]
  always_comb begin
    temp = prev;
    if (wi[1:0] == 2'b00) temp = sub ^ {rcon, 24'h0};
    nxt = back4 ^ temp;
  end

  // round-key read port; indices past 10 read zero
  always_comb begin
    base   = (rk_addr > 4'd10) ? 6'd0 : {rk_addr, 2'b00};
    rk_out = {w[base], w[base + 6'd1],
              w[base + 6'd2], w[base + 6'd3]};
    if (rk_addr > 4'd10) rk_out = '0;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = EXPAND;
      EXPAND:  if (i == 6'd43) state_n = DONE;
      DONE:    if (accept) state_n = EXPAND;
      default: state_n = IDLE;
    endcase
  end

  // key load, word generation, rcon and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 44; k++) w[k] <= '0;
      i      <= '0;
      rcon   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == EXPAND) && (i == 6'd43);
      if (accept) begin
        w[0] <= key_in[127:96];
        w[1] <= key_in[95:64];
        w[2] <= key_in[63:32];
        w[3] <= key_in[31:0];
        i    <= 6'd4;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        w[wi] <= nxt;
        if (wi[1:0] == 2'b00) rcon <= xtime(rcon);
        if (i != 6'd43) i <= i + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: FIPS/zero/random keys vs. a
// textbook key-expansion model, plus handshake and reset cases.

module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];
  logic [7:0]   rc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08,
    8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_addr   (rk_addr),
    .rk_out    (rk_out),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  always #50 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // S-box table built from the generator-walk construction
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
          ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model(input logic [127:0] key);
    logic [31:0] ws [0:43];
    logic [31:0] t;
    for (int k = 0; k < 4; k++) ws[k] = key[127-32*k -: 32];
    for (int k = 4; k < 44; k++) begin
      t = ws[k-1];
      if (k % 4 == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rc_tab[k/4-1], 24'h0};
      ws[k] = ws[k-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
  endtask

  task automatic chk_rk(input string tag, input int r,
                        input logic [127:0] exp);
    rk_addr = 4'(r);
    #1;
    check($sformatf("%s_rk%0d", tag, r), rk_out, exp);
  endtask

  // called at a negedge with key_ready=1; returns at negedge after accept
  task automatic start_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    check("accept_busy", busy, 1'b1);
    check("accept_ready", key_ready, 1'b0);
  endtask

  // from negedge after accept: partial reads, latency, full schedule
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 60) begin
      if (n % 4 == 0 && n <= 40) chk_rk({tag, "_mid"}, n / 4, exp_rk[n/4]);
      if (done) break;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd40);
    check({tag, "_rk_valid"}, rk_valid, 1'b1);
    check({tag, "_ready"}, key_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    for (int r = 0; r < 11; r++) chk_rk(tag, r, exp_rk[r]);
  endtask

  initial begin
    logic [127:0] ka;
    logic [127:0] kb;
    int cnt;
    build_sbox();
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_addr   = '0;
    @(negedge clk);
    check("rst_ready", key_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", rk_valid, 1'b0);
    chk_rk("rst", 0, '0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key
    model(FIPS);
    start_key(FIPS);
    wait_done("fips");
    chk_rk("fips_lit", 0, FIPS);
    chk_rk("fips_lit", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    chk_rk("fips_lit", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("valid_hold", rk_valid, 1'b1);
    for (int a = 11; a < 16; a++) chk_rk("oob", a, '0);

    // re-key in DONE with zero key
    model('0);
    start_key('0);
    check("rekey_valid_drop", rk_valid, 1'b0);
    wait_done("zero");
    chk_rk("zero_lit", 1, 128'h62636363626363636263636362636363);
    chk_rk("zero_lit", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // random keys, accepted in the same cycle done is high
    for (int t = 0; t < 3; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      model(ka);
      key_in    = ka;
      key_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      check("same_done", done, 1'b0);
      check("same_valid", rk_valid, 1'b0);
      check("same_busy", busy, 1'b1);
      wait_done("rand");
    end

    // key_valid held with another key during expansion
    @(negedge clk);
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka ^ {4{$urandom}};
    model(ka);
    key_in    = ka;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_in = kb;
    cnt = 0;
    for (int n = 0; n < 60 && !key_ready; n++) begin
      cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    check("hold_ready_low", 128'(cnt), 128'd40);
    check("hold_done", done, 1'b1);
    for (int r = 0; r < 11; r++) chk_rk("hold_first", r, exp_rk[r]);
    model(kb);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    check("hold_second_busy", busy, 1'b1);
    check("hold_second_valid", rk_valid, 1'b0);
    wait_done("hold_second");

    // asynchronous reset mid-expansion
    @(negedge clk);
    start_key(FIPS);
    repeat (20) @(posedge clk);
    #10;
    rst = 1'b1;
    #1;
    check("arst_ready", key_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_valid", rk_valid, 1'b0);
    for (int a = 0; a < 16; a++) chk_rk("arst", a, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model(FIPS);
    start_key(FIPS);
    wait_done("after_rst");
    chk_rk("after_rst_lit", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
